// File: rtl/ram2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram2_pkg
//  Description : Shared constants and state type for the ram2 storage macro.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram2_pkg;

   localparam int C_DATA_W = 8;
   localparam int C_ADDR_W = 10;

   // CLEAR: array being zeroed, user accesses ignored.
   // READY: array accepts user accesses.
   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram2_state_t;

endpackage
`default_nettype wire

// File: rtl/ram2_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram2_clear_seq
//  Description : Power-on clear sequencer for ram2. Owns the clear pointer,
//                the CLEAR/READY state and the ready flag, and muxes the
//                array write port between clear writes and user writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram2_clear_seq
   import ram2_pkg::*;
#(
   parameter int DATA_W         = C_DATA_W,
   parameter int ADDR_W         = C_ADDR_W,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              user_sel,
   input  logic              user_wr,
   input  logic [ADDR_W-1:0] user_addr,
   input  logic [DATA_W-1:0] user_wdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              ready
);

   localparam logic [ADDR_W:0] C_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   // One extra pointer bit so that stepping past the last word sets the MSB.
   logic [ADDR_W:0] r_ptr;
   logic [ADDR_W:0] w_ptr_nxt;
   ram2_state_t     r_state;
   ram2_state_t     w_state_nxt;

   // State and clear pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Next-state logic and write-port mux: clear writes own the port until READY.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      mem_we      = 1'b0;
      mem_waddr   = user_addr;
      mem_wdata   = user_wdata;
      case (r_state)
         CLEAR: begin
            if (CLEAR_ON_RESET != 0) begin
               mem_we    = 1'b1;
               mem_waddr = r_ptr[ADDR_W-1:0];
               mem_wdata = '0;
               w_ptr_nxt = r_ptr + C_PTR_ONE;
               // Terminal count: last word written on this edge.
               if (w_ptr_nxt[ADDR_W]) begin
                  w_state_nxt = READY;
               end
            end else begin
               w_state_nxt = READY;
            end
         end
         READY: begin
            mem_we = user_sel & user_wr;
         end
         default: begin
            w_state_nxt = CLEAR;
         end
      endcase
   end

   assign ready = (r_state == READY);

endmodule
`default_nettype wire

// File: rtl/ram2.sv
`default_nettype none
// ============================================================================
//  Module      : ram2
//  Description : Single-port synchronous RAM with registered read data and a
//                power-on clear sequencer. One shared address bus; select
//                qualifies each access and write chooses its direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram2
   import ram2_pkg::*;
#(
   parameter int DATA_W         = C_DATA_W,
   parameter int ADDR_W         = C_ADDR_W,
   parameter int DEPTH          = 2**ADDR_W,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] address,
   input  logic              write,
   input  logic              select,
   output logic              ready
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_data_out;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_ready;

   ram2_clear_seq #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .user_sel   (select),
      .user_wr    (write),
      .user_addr  (address),
      .user_wdata (data_in),
      .mem_we     (w_we),
      .mem_waddr  (w_waddr),
      .mem_wdata  (w_wdata),
      .ready      (w_ready)
   );

   // Synchronous write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   // Registered read port; holds its value on idle cycles and writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= '0;
      end else if (w_ready && select && !write) begin
         r_data_out <= r_mem[address];
      end
   end

   assign data_out = r_data_out;
   assign ready    = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_ram2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram2
//  Description : Self-checking bench for ram2 with a queue-based scoreboard
//                and an array reference model of the storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram2;

   localparam int C_DEPTH = 1024;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rst_n1 = 1'b0;
   logic [7:0] data_in = '0;
   logic [9:0] address = '0;
   logic       write = 1'b0;
   logic       select = 1'b0;
   logic       select1 = 1'b0;
   logic [7:0] data_out;
   logic [7:0] data_out1;
   logic       ready;
   logic       ready1;

   int         checks = 0;
   int         errors = 0;

   // Reference model: storage contents, edges since reset release, scoreboard.
   logic [7:0] m_mem [C_DEPTH];
   int         m_since = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_dout = '0;
   bit         rd_flag = 1'b0;

   always #5 clk = ~clk;

   ram2 u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_out (data_out),
      .data_in  (data_in),
      .address  (address),
      .write    (write),
      .select   (select),
      .ready    (ready)
   );

   ram2 #(.CLEAR_ON_RESET(0)) u_dut_nc (
      .clk      (clk),
      .rst_n    (rst_n1),
      .data_out (data_out1),
      .data_in  (data_in),
      .address  (address),
      .write    (write),
      .select   (select1),
      .ready    (ready1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus; the model decides whether it is accepted.
   task automatic acc(input bit sel, input bit wr, input logic [9:0] a, input logic [7:0] d);
      @(negedge clk);
      select  = sel;
      write   = wr;
      address = a;
      data_in = d;
      if (sel && m_since >= C_DEPTH) begin
         if (wr) begin
            m_mem[a] = d;
         end else begin
            exp_q.push_back(m_mem[a]);
            rd_flag = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         acc(1'b0, 1'($urandom), 10'($urandom), 8'($urandom));
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic do_reset;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("reset_data_out", data_out, 0);
      chk("reset_ready", ready, 0);
      exp_q.delete();
      rd_flag  = 1'b0;
      exp_dout = '0;
      m_since  = 0;
      repeat (2) @(negedge clk);
      select = 1'b0;
      rst_n  = 1'b1;
   endtask

   // Monitor: pops expected read data on read edges, checks every cycle.
   initial begin
      bit issued;
      forever begin
         @(posedge clk);
         if (rst_n) begin
            issued  = rd_flag;
            rd_flag = 1'b0;
            if (m_since < C_DEPTH) begin
               m_since++;
               if (m_since == C_DEPTH) begin
                  for (int k = 0; k < C_DEPTH; k++) m_mem[k] = 8'h00;
               end
            end
            if (issued) begin
               if (exp_q.size() == 0) begin
                  chk("scoreboard_underflow", 1, 0);
               end else begin
                  exp_dout = exp_q.pop_front();
               end
            end
            #1;
            chk("data_out", data_out, exp_dout);
            chk("ready", ready, (m_since >= C_DEPTH) ? 1 : 0);
         end
      end
   end

   initial begin
      logic [9:0] a;
      // Power-on reset.
      repeat (2) @(negedge clk);
      chk("por_data_out", data_out, 0);
      chk("por_ready", ready, 0);
      rst_n = 1'b1;

      // Accesses during the clear phase must be ignored.
      for (int i = 0; i < 20; i++) acc(1'b1, (i % 2) == 0, 10'(i), 8'hFF);
      idle(C_DEPTH - 20 + 2);

      // Cleared contents.
      acc(1'b1, 1'b0, 10'd0, 8'h00);
      acc(1'b1, 1'b0, 10'd511, 8'h00);
      acc(1'b1, 1'b0, 10'd1023, 8'h00);
      acc(1'b1, 1'b0, 10'd4, 8'h00);

      // Write then read.
      acc(1'b1, 1'b1, 10'd5, 8'd10);
      acc(1'b1, 1'b0, 10'd5, 8'h00);
      idle(2);

      // Full sweep of 2k mod 256.
      for (int k = 0; k < C_DEPTH; k++) acc(1'b1, 1'b1, 10'(k), 8'((2 * k) & 255));
      acc(1'b1, 1'b0, 10'd200, 8'h00);
      acc(1'b1, 1'b0, 10'd1023, 8'h00);
      for (int i = 0; i < 18; i++) acc(1'b1, 1'b0, 10'($urandom), 8'h00);

      // Hold: unselected cycles with random controls.
      idle(20);
      for (int i = 0; i < 8; i++) acc(1'b1, 1'b0, 10'($urandom), 8'h00);

      // Random mixed traffic, including back-to-back reads.
      for (int i = 0; i < 400; i++) begin
         a = 10'($urandom);
         acc(($urandom % 4) != 0, 1'($urandom), a, 8'($urandom));
      end
      acc(1'b1, 1'b1, 10'd9, 8'hA7);
      acc(1'b1, 1'b0, 10'd9, 8'h00);

      // Reset mid-operation, then mid-clear at cycle 300.
      do_reset();
      idle(300);
      do_reset();
      idle(C_DEPTH + 2);
      acc(1'b1, 1'b0, 10'd5, 8'h00);
      acc(1'b1, 1'b0, 10'd9, 8'h00);
      acc(1'b1, 1'b0, 10'd200, 8'h00);
      acc(1'b1, 1'b0, 10'd1023, 8'h00);
      idle(3);
      chk("scoreboard_drain", exp_q.size(), 0);

      // Variant without clear: ready on first edge after release.
      @(negedge clk);
      select = 1'b0;
      #1;
      chk("nc_reset_ready", ready1, 0);
      chk("nc_reset_data_out", data_out1, 0);
      @(negedge clk);
      rst_n1 = 1'b1;
      @(posedge clk);
      #1;
      chk("nc_ready", ready1, 1);
      @(negedge clk);
      select1 = 1'b1; write = 1'b1; address = 10'd77; data_in = 8'h5A;
      @(negedge clk);
      write = 1'b0; data_in = 8'h00;
      @(negedge clk);
      select1 = 1'b0;
      chk("nc_readback", data_out1, 8'h5A);
      @(negedge clk);
      chk("nc_hold", data_out1, 8'h5A);
      chk("nc_ready_stays", ready1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram2.md
# ram2

Single-port synchronous RAM, 1024 x 8 by default, with a registered read port and a power-on clear sequencer. One address bus is shared by reads and writes. `select` qualifies every access and `write` chooses the direction. The block is a generic storage macro for datapath blocks that need addressable scratch memory with deterministic (all-zero) contents after reset.

## Interface
Parameters:
- `DATA_W`, default 8: word width.
- `ADDR_W`, default 10: address width.
- `DEPTH`, default 2**ADDR_W (1024): number of words. Always equals 2**ADDR_W.
- `CLEAR_ON_RESET`, default 1: when 1, every word is zeroed after reset release.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `data_out`, output, DATA_W: registered read data.
- `data_in`, input, DATA_W: write data.
- `address`, input, ADDR_W: word address for both reads and writes.
- `write`, input, 1: 1 = write, 0 = read. Only meaningful when `select`=1.
- `select`, input, 1: access enable.
- `ready`, output, 1: 1 = the array accepts accesses.

## Operation
- Reset (`rst_n`=0, asynchronous): `data_out`=0, `ready`=0, clear pointer=0. Array contents are not touched by reset itself.
- Clear phase (`CLEAR_ON_RESET`=1): from the first edge after `rst_n` rises, one word is zeroed per cycle at addresses 0, 1, …, DEPTH-1.
  - `ready` rises on the edge after address DEPTH-1 is written.
  - User accesses during the clear phase are ignored and `data_out` holds 0.
- `CLEAR_ON_RESET`=0: `ready`=1 on the first edge after reset release. Contents are undefined until written.
- Accesses when `ready`=1, decoded on each rising edge:
  - `select`=1, `write`=1: mem[address] <= data_in. `data_out` unchanged.
  - `select`=1, `write`=0: data_out <= mem[address].
  - `select`=0: no access. `data_out` holds its last value.
- At most one access per cycle. There is no separate read-during-write case.
- Width rules:
  - `data_in` is stored exactly as presented. Callers truncate wider values, so they keep only the low DATA_W bits.
  - `address` spans exactly DEPTH, so there is no out-of-range case.
  - The clear pointer is ADDR_W+1 bits so its terminal count is detectable.

## Timing
- Write: data is visible to a read issued on the very next cycle.
- Read latency: 1 cycle. Address sampled at edge N, data valid on `data_out` after edge N.
- Back-to-back reads to different addresses: one result per cycle.
- Clear phase: exactly DEPTH cycles from reset release to `ready`=1.
- Reset asserted mid-clear or mid-operation:
  - Immediate return to the reset state.
  - The clear restarts from address 0 after release.
  - Words already written keep their values unless re-cleared.
- `ready` never drops except on reset.

## Structure
- Shared package `ram2_pkg`: default `DATA_W`/`ADDR_W` constants and the `ram2_state_t` enum (CLEAR, READY).
- Sub-module `ram2_clear_seq` owns the clear pointer, the state and `ready`. It drives the array's write port mux (clear write vs user write).
- The top level holds the memory array (inferred RAM, a synchronous write port with a registered read) and the `data_out` register.

## Test plan
- Reset then clear: release `rst_n` → `ready`=0 for exactly 1024 cycles, then 1. Reading address 0, 511 and 1023 → `data_out`=0 for each.
- Write then read: write 10 to address 5, then read address 5 → `data_out`=10 one cycle after the read edge.
- Full sweep: write (2k mod 256) to every address k, then read 20 pseudo-random addresses. Each read → low 8 bits of 2k (e.g. address 200 → 144, address 1023 → 254).
- Hold and ignore: `select`=0 with arbitrary `write`/`address`/`data_in` → `data_out` and contents unchanged. Accesses issued during the clear phase → no effect.
- Mid-clear reset: assert `rst_n`=0 at clear cycle 300 → `data_out`=0 and `ready`=0 immediately. After release, `ready` rises after another 1024 cycles.
- `CLEAR_ON_RESET`=0: `ready`=1 one cycle after release. A write followed by a read returns the written value.
